alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_pkg.sv | 21 ++
 rtl/skid_fifo2.sv | 69 ++++++
 rtl/alu_result_stage.sv | 73 +++++++
 tb/tb_alu_result_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: default widths, the flag-class
// encoding presented by the adder, and the {N,Z,V} flag register layout.
package alu_pkg;

   localparam int ALU_DATA_W = 16;
   localparam int ALU_RD_W   = 4;

   // 2'b11 is deliberately left out; the stage treats it like FCLS_NONE.
   typedef enum logic [1:0] {
      FCLS_NONE = 2'b00,
      FCLS_Z    = 2'b01,
      FCLS_NZV  = 2'b10
   } fcls_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
   } flags_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order buffer; the head entry is always presented on rdata so a
// push into an empty buffer is visible one cycle later.
module skid_fifo2 #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [1:0]   count
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q != 2'd2) begin
                  if (count_q == 2'd0) head_d = wdata;
                  else                 tail_d = wdata;
                  count_d = count_q + 2'd1;
               end
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            // Simultaneous push and pop keeps the occupancy; the new entry
            // lands wherever the departing head leaves a slot.
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = wdata;
               end else begin
                  head_d = tail_q;
                  tail_d = wdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rdata = head_q;
   assign count = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers adder results and maintains the {N,Z,V} flags.
// Define ALU_FLAG_BYPASS_EN to expose the flag update in the same cycle as the push.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int RD_W   = ALU_RD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_ovfl,
   input  logic [1:0]        in_fcls,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic [2:0]        flags
);

   logic [1:0]  count;
   logic        push;
   logic        pop;
   flags_t      flags_q, flags_d;

   assign in_ready  = rst_n & (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   skid_fifo2 #(
      .W(DATA_W + RD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({in_result, in_rd}),
      .rdata ({out_result, out_rd}),
      .count (count)
   );

   // Flags only move on an accepted push; class 2'b11 falls through as NONE.
   always_comb begin
      flags_d = flags_q;
      if (push) begin
         if (in_fcls == FCLS_NZV) begin
            flags_d.n = in_result[DATA_W-1];
            flags_d.z = (in_result == '0);
            flags_d.v = in_ovfl;
         end else if (in_fcls == FCLS_Z) begin
            flags_d.z = (in_result == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

`ifdef ALU_FLAG_BYPASS_EN
   assign flags = flags_d;
`else
   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_ovfl;
   logic [1:0]  in_fcls;
   logic [3:0]  in_rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_rd;
   logic [2:0]  flags;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  rd;
   } ent_t;

   ent_t       mq[$];
   logic [2:0] mflags;
   bit         m_push;
   bit         m_pop;

   alu_result_stage #(
      .DATA_W(16),
      .RD_W  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_ovfl   (in_ovfl),
      .in_fcls   (in_fcls),
      .in_rd     (in_rd),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_rd    (out_rd),
      .flags     (flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flag rule written straight from the class table: {N,Z,V}.
   function automatic logic [2:0] next_flags(input logic [2:0] f, input logic [1:0] c,
                                             input logic [15:0] r, input logic ov);
      if (c == 2'd2) return {r[15], (r == 16'd0), ov};
      if (c == 2'd1) return {f[2], (r == 16'd0), f[0]};
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-order queue plus a flag variable.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mflags = 3'b000;
      end else begin
         m_push = in_valid && (mq.size() < 2) && !flush;
         m_pop  = (mq.size() > 0) && out_ready && !flush;
         if (flush) mq.delete();
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            mq.push_back('{res: in_result, rd: in_rd});
            mflags = next_flags(mflags, in_fcls, in_result, in_ovfl);
         end
      end
   end

   // Mid-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [2:0] exp_flags;
      checkOutput("in_ready", in_ready, rst_n && (mq.size() < 2));
      checkOutput("out_valid", out_valid, mq.size() != 0);
      if (!rst_n) begin
         checkOutput("out_result_rst", out_result, 0);
         checkOutput("out_rd_rst", out_rd, 0);
      end else if (mq.size() != 0) begin
         checkOutput("out_result", out_result, mq[0].res);
         checkOutput("out_rd", out_rd, mq[0].rd);
      end
      exp_flags = mflags;
`ifdef ALU_FLAG_BYPASS_EN
      if (rst_n && in_valid && (mq.size() < 2) && !flush)
         exp_flags = next_flags(mflags, in_fcls, in_result, in_ovfl);
`endif
      checkOutput("flags", flags, exp_flags);
   end

   // Drive one cycle of inputs across the next rising edge, then go idle.
   task automatic applyStimulus(input logic v, input logic [15:0] r, input logic ov,
                                input logic [1:0] fc, input logic [3:0] rd,
                                input logic ordy, input logic fl);
      in_valid  = v;
      in_result = r;
      in_ovfl   = ov;
      in_fcls   = fc;
      in_rd     = rd;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_result = 16'h0;
      in_ovfl   = 1'b0;
      in_fcls   = 2'b00;
      in_rd     = 4'h0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_flags", flags, 3'b000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("post_reset_in_ready", in_ready, 1);

      // Basic push, one-cycle latency
      applyStimulus(1, 16'h5555, 0, 2'b10, 4'd3, 1, 0);
      checkOutput("d1_out_valid", out_valid, 1);
      checkOutput("d1_out_result", out_result, 16'h5555);
      checkOutput("d1_out_rd", out_rd, 4'd3);
      checkOutput("d1_flags", flags, 3'b000);
      applyStimulus(0, 16'h0, 0, 2'b00, 4'd0, 1, 0);
      checkOutput("d1_drained", out_valid, 0);

      // Overflow into positive then negative saturation; second push overlaps a pop
      applyStimulus(1, 16'h7FFF, 1, 2'b10, 4'd1, 1, 0);
      checkOutput("d2_flags_a", flags, 3'b001);
      applyStimulus(1, 16'h8000, 1, 2'b10, 4'd2, 1, 0);
      checkOutput("d2_flags_b", flags, 3'b101);
      checkOutput("d2_model_flags", mflags, 3'b101);
      checkOutput("d2_out_result", out_result, 16'h8000);
      checkOutput("d2_out_rd", out_rd, 4'd2);

      // Z_ONLY, NONE and the reserved class
      applyStimulus(1, 16'h0000, 0, 2'b01, 4'd4, 1, 0);
      checkOutput("d3_flags_z", flags, 3'b111);
      applyStimulus(1, 16'h1234, 0, 2'b00, 4'd5, 1, 0);
      checkOutput("d3_flags_none", flags, 3'b111);
      applyStimulus(1, 16'h0001, 0, 2'b11, 4'd5, 1, 0);
      checkOutput("d3_flags_cls3", flags, 3'b111);
      checkOutput("d3_model_flags", mflags, 3'b111);
      applyStimulus(0, 16'h0, 0, 2'b00, 4'd0, 1, 0);

      // Back-pressure: fill, blocked third push, in-order drain
      applyStimulus(1, 16'h1111, 0, 2'b00, 4'd6, 0, 0);
      applyStimulus(1, 16'h2222, 0, 2'b00, 4'd7, 0, 0);
      checkOutput("d4_in_ready", in_ready, 0);
      checkOutput("d4_head", out_result, 16'h1111);
      applyStimulus(1, 16'h3333, 0, 2'b10, 4'd8, 0, 0);
      checkOutput("d4_blocked_flags", flags, 3'b111);
      checkOutput("d4_head_held", out_result, 16'h1111);
      checkOutput("d4_rd_held", out_rd, 4'd6);
      applyStimulus(0, 16'h0, 0, 2'b00, 4'd0, 1, 0);
      checkOutput("d4_second", out_result, 16'h2222);
      checkOutput("d4_second_rd", out_rd, 4'd7);
      applyStimulus(0, 16'h0, 0, 2'b00, 4'd0, 1, 0);
      checkOutput("d4_empty", out_valid, 0);

      // Flush with two buffered entries, then flush on an empty buffer
      applyStimulus(1, 16'hAAAA, 0, 2'b10, 4'd9, 0, 0);
      checkOutput("d5_flags", flags, 3'b100);
      applyStimulus(1, 16'h0001, 0, 2'b00, 4'd10, 0, 0);
      applyStimulus(1, 16'h0000, 1, 2'b10, 4'd11, 0, 1);
      checkOutput("d5_flush_valid", out_valid, 0);
      checkOutput("d5_flush_flags", flags, 3'b100);
      applyStimulus(1, 16'h0000, 1, 2'b10, 4'd12, 1, 1);
      checkOutput("d5_flush_in_lost", out_valid, 0);
      checkOutput("d5_flush_flags2", flags, 3'b100);

      // Asynchronous reset with a full buffer
      applyStimulus(1, 16'h4321, 0, 2'b10, 4'd1, 0, 0);
      applyStimulus(1, 16'h8765, 1, 2'b10, 4'd2, 0, 0);
      checkOutput("d6_pre_flags", flags, 3'b101);
      rst_n = 1'b0;
      #1;
      checkOutput("d6_rst_valid", out_valid, 0);
      checkOutput("d6_rst_result", out_result, 0);
      checkOutput("d6_rst_rd", out_rd, 0);
      checkOutput("d6_rst_flags", flags, 3'b000);
      checkOutput("d6_rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      applyStimulus(1, 16'h0F0F, 0, 2'b10, 4'd5, 1, 0);
      checkOutput("d6_first_accept", out_result, 16'h0F0F);
      checkOutput("d6_first_flags", flags, 3'b000);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [2:0] pick;
         @(posedge clk);
         #1;
         pick = 3'($urandom_range(0, 4));
         in_valid  = ($urandom % 4) != 0;
         in_result = (pick == 0) ? 16'h0000 :
                     (pick == 1) ? 16'h7FFF :
                     (pick == 2) ? 16'h8000 : 16'($urandom);
         in_ovfl   = 1'($urandom);
         in_fcls   = 2'($urandom);
         in_rd     = 4'($urandom);
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 16) == 0;
         rst_n     = !(i == 300);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
